// File: rtl/if_id_fetch_queue_pkg.sv
// Shared constants and entry layout for the IF->ID fetch queue.
// An entry is {Instr, PC+4, PC+8}, 96 bits, instruction in the top word.
package if_id_fetch_queue_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 2;

    localparam int FIELD_W   = 32;
    localparam int ENTRY_W   = 96;

    localparam int INSTR_LSB = 64;
    localparam int PC4_LSB   = 32;
    localparam int PC8_LSB   = 0;

    typedef struct packed {
        logic [FIELD_W-1:0] instr;
        logic [FIELD_W-1:0] pc4;
        logic [FIELD_W-1:0] pc8;
    } fetch_entry_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [FIELD_W-1:0] instr,
        input logic [FIELD_W-1:0] pc4,
        input logic [FIELD_W-1:0] pc8
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[INSTR_LSB +: FIELD_W] = instr;
        e[PC4_LSB   +: FIELD_W] = pc4;
        e[PC8_LSB   +: FIELD_W] = pc8;
        return e;
    endfunction

endpackage

// File: rtl/if_id_fetch_queue_fifo_storage_96.sv
// DEPTH x 96 register array: one synchronous write port, one asynchronous
// read port, all entries cleared by the asynchronous active-low reset.
module fifo_storage_96
    import if_id_fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [ENTRY_W-1:0] o_rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF->ID fetch queue: captures each fetched {Instr, PC+4, PC+8} triple,
// backpressures IF through if_en and hands the oldest entry to ID.
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instr_F,
    input  logic [31:0]       PC4_F,
    input  logic [31:0]       PC8_F,
    input  logic              flush,
    output logic              if_en,
    input  logic              id_ready,
    output logic              valid_D,
    output logic [31:0]       Instr_D,
    output logic [31:0]       PC4_D,
    output logic [31:0]       PC8_D,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;
    fetch_entry_t       w_head;

    // Handshakes: IF side transfers on every edge where if_en=1 and flush=0;
    // ID side transfers on every edge where valid_D=1, id_ready=1, flush=0.
    // if_en is built only from the registered count and flush, so there is
    // no combinational path from id_ready back to IF.
    assign w_full  = (r_count == FULL_CNT);
    assign if_en   = ~w_full | flush;
    assign valid_D = (r_count != '0);
    assign w_push  = if_en & ~flush;
    assign w_pop   = valid_D & id_ready & ~flush;
    assign count   = r_count;

    assign w_wdata = pack_entry(Instr_F, PC4_F, PC8_F);

    fifo_storage_96 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .i_rst_n (reset),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign w_head  = fetch_entry_t'(w_rdata);
    assign Instr_D = w_head.instr;
    assign PC4_D   = w_head.pc4;
    assign PC8_D   = w_head.pc8;

    // A redirect drops every queued wrong-path entry and realigns both pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue: an IF model feeds consecutive PCs, a queue
// reference model tracks the expected contents, scenario tasks check outputs.
module tb_if_id_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_F, PC4_F, PC8_F;
    logic        flush, id_ready;
    logic        if_en, valid_D;
    logic [31:0] Instr_D, PC4_D, PC8_D;
    logic [AW:0] count;

    int errors = 0;
    int checks = 0;

    logic [95:0] exp_q[$];
    logic [31:0] pc;

    if_id_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .Instr_F  (Instr_F),
        .PC4_F    (PC4_F),
        .PC8_F    (PC8_F),
        .flush    (flush),
        .if_en    (if_en),
        .id_ready (id_ready),
        .valid_D  (valid_D),
        .Instr_D  (Instr_D),
        .PC4_D    (PC4_D),
        .PC8_D    (PC8_D),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    function automatic logic [95:0] entry_of(input logic [31:0] a);
        return {instr_of(a), a + 32'd4, a + 32'd8};
    endfunction

    task automatic drive_if();
        Instr_F = instr_of(pc);
        PC4_F   = pc + 32'd4;
        PC8_F   = pc + 32'd8;
    endtask

    // One clock edge: reference model follows the queue rules, IF model
    // advances the PC when enabled or loads npc on a redirect.
    task automatic tick(input logic [31:0] npc);
        bit m_if_en, push, pop;
        logic [95:0] tmp;
        m_if_en = (exp_q.size() < DEPTH) || flush;
        push    = m_if_en && !flush;
        pop     = (exp_q.size() != 0) && id_ready && !flush;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (pop) tmp = exp_q.pop_front();
            if (push) exp_q.push_back(entry_of(pc));
        end
        if (flush) pc = npc;
        else if (m_if_en) pc = pc + 32'd4;
        #1 drive_if();
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; id_ready = 1'b0;
        pc = 32'h3000; drive_if(); exp_q.delete();
        #12;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_D); end
        checks++; if (if_en !== 1'b1) begin errors++; $display("FAIL reset_if_en: got %b expected 1", if_en); end
        checks++; if ({Instr_D, PC4_D, PC8_D} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {Instr_D, PC4_D, PC8_D}); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fill_stall();
        id_ready = 1'b0;
        tick(32'd0);
        checks++; if (valid_D !== 1'b1) begin errors++; $display("FAIL fill_first_valid: got %b expected 1", valid_D); end
        checks++; if (Instr_D !== instr_of(32'h3000)) begin errors++; $display("FAIL fill_first_instr: got %h expected %h", Instr_D, instr_of(32'h3000)); end
        checks++; if (PC4_D !== 32'h3004 || PC8_D !== 32'h3008) begin errors++; $display("FAIL fill_first_pc: got %h/%h expected 3004/3008", PC4_D, PC8_D); end
        repeat (3) tick(32'd0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
        checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL fill_if_en: got %b expected 0", if_en); end
        repeat (2) tick(32'd0);
        checks++; if (count !== 3'd4 || if_en !== 1'b0) begin errors++; $display("FAIL full_hold: got count=%0d if_en=%b expected 4/0", count, if_en); end
        checks++; if (PC4_D !== 32'h3004) begin errors++; $display("FAIL full_head: got %h expected 3004", PC4_D); end
    endtask

    task automatic test_single_pop();
        id_ready = 1'b1;
        tick(32'd0);
        id_ready = 1'b0;
        checks++; if (PC4_D !== 32'h3008 || Instr_D !== instr_of(32'h3004)) begin errors++; $display("FAIL pop_head: got %h/%h expected %h/3008", Instr_D, PC4_D, instr_of(32'h3004)); end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL pop_count: got %0d expected 3", count); end
        checks++; if (if_en !== 1'b1) begin errors++; $display("FAIL pop_if_en: got %b expected 1", if_en); end
        tick(32'd0);
        checks++; if (count !== 3'd4 || if_en !== 1'b0) begin errors++; $display("FAIL pop_refill: got count=%0d if_en=%b expected 4/0", count, if_en); end
        checks++; if (exp_q[3] !== entry_of(32'h3010)) begin errors++; $display("FAIL pop_model_tail: got %h expected %h", exp_q[3], entry_of(32'h3010)); end
    endtask

    task automatic test_steady();
        flush = 1'b1; id_ready = 1'b1;
        tick(32'h3800);
        flush = 1'b0;
        checks++; if (count !== 3'd0 || valid_D !== 1'b0) begin errors++; $display("FAIL steady_flush: got count=%0d valid=%b expected 0/0", count, valid_D); end
        tick(32'd0);
        checks++; if (count !== 3'd1 || PC4_D !== 32'h3804) begin errors++; $display("FAIL steady_first: got count=%0d pc4=%h expected 1/3804", count, PC4_D); end
        for (int i = 0; i < 50; i++) begin
            tick(32'd0);
            checks++;
            if (count !== 3'd1 || valid_D !== 1'b1 || PC4_D !== 32'h3808 + 32'(4 * i)) begin
                errors++;
                $display("FAIL steady_flow[%0d]: got count=%0d valid=%b pc4=%h expected 1/1/%h", i, count, valid_D, PC4_D, 32'h3808 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_flush_full();
        id_ready = 1'b0;
        repeat (3) tick(32'd0);
        checks++; if (count !== 3'd4 || if_en !== 1'b0) begin errors++; $display("FAIL ff_full: got count=%0d if_en=%b expected 4/0", count, if_en); end
        flush = 1'b1;
        #1;
        checks++; if (if_en !== 1'b1) begin errors++; $display("FAIL ff_if_en_forced: got %b expected 1", if_en); end
        tick(32'h3400);
        flush = 1'b0;
        checks++; if (count !== 3'd0 || valid_D !== 1'b0) begin errors++; $display("FAIL ff_empty: got count=%0d valid=%b expected 0/0", count, valid_D); end
        tick(32'd0);
        checks++; if (valid_D !== 1'b1 || Instr_D !== instr_of(32'h3400)) begin errors++; $display("FAIL ff_target_instr: got %h expected %h", Instr_D, instr_of(32'h3400)); end
        checks++; if (PC4_D !== 32'h3404 || PC8_D !== 32'h3408) begin errors++; $display("FAIL ff_target_pc: got %h/%h expected 3404/3408", PC4_D, PC8_D); end
    endtask

    task automatic test_flush_pop();
        id_ready = 1'b0;
        tick(32'd0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL fp_setup: got %0d expected 2", count); end
        id_ready = 1'b1; flush = 1'b1;
        tick(32'h3600);
        id_ready = 1'b0; flush = 1'b0;
        checks++; if (count !== 3'd0 || valid_D !== 1'b0) begin errors++; $display("FAIL fp_cleared: got count=%0d valid=%b expected 0/0", count, valid_D); end
        repeat (4) tick(32'd0);
        checks++; if (count !== 3'd4 || PC4_D !== 32'h3604) begin errors++; $display("FAIL fp_realign: got count=%0d pc4=%h expected 4/3604", count, PC4_D); end
        id_ready = 1'b1;
        repeat (3) tick(32'd0);
        id_ready = 1'b0;
        checks++; if (PC4_D !== 32'h3610) begin errors++; $display("FAIL fp_order: got %h expected 3610", PC4_D); end
    endtask

    task automatic test_async_reset();
        id_ready = 1'b0;
        flush = 1'b1;
        tick(32'h4000);
        flush = 1'b0;
        repeat (3) tick(32'd0);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL ar_setup: got %0d expected 3", count); end
        #3 reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || valid_D !== 1'b0 || if_en !== 1'b1) begin errors++; $display("FAIL ar_immediate: got count=%0d valid=%b if_en=%b expected 0/0/1", count, valid_D, if_en); end
        checks++; if ({Instr_D, PC4_D, PC8_D} !== 96'd0) begin errors++; $display("FAIL ar_data: got %h expected 0", {Instr_D, PC4_D, PC8_D}); end
        exp_q.delete();
        pc = 32'h5000; drive_if();
        #1 reset = 1'b1;
        tick(32'd0);
        checks++; if (count !== 3'd1 || valid_D !== 1'b1 || PC4_D !== 32'h5004 || Instr_D !== instr_of(32'h5000)) begin errors++; $display("FAIL ar_resume: got count=%0d instr=%h pc4=%h expected 1/%h/5004", count, Instr_D, PC4_D, instr_of(32'h5000)); end
    endtask

    task automatic test_random();
        logic [31:0] npc;
        logic [95:0] head;
        bit exp_if_en;
        for (int i = 0; i < 400; i++) begin
            id_ready = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 15) == 0);
            npc      = $urandom & 32'hFFFF_FFFC;
            #1;
            exp_if_en = (exp_q.size() < DEPTH) || flush;
            checks++; if (if_en !== exp_if_en) begin errors++; $display("FAIL rnd_if_en[%0d]: got %b expected %b", i, if_en, exp_if_en); end
            tick(npc);
            checks++; if (count !== 3'(exp_q.size()) || valid_D !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_count[%0d]: got count=%0d valid=%b expected %0d", i, count, valid_D, exp_q.size()); end
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                checks++; if ({Instr_D, PC4_D, PC8_D} !== head) begin errors++; $display("FAIL rnd_head[%0d]: got %h expected %h", i, {Instr_D, PC4_D, PC8_D}, head); end
            end
        end
        flush = 1'b0; id_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_single_pop();
        test_steady();
        test_flush_full();
        test_flush_pop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Receiving end of the instruction-fetch interface; sits between the IF stage and ID.
- Captures each fetched {Instr, PC+4, PC+8} triple into a small circular queue.
- Drives the IF stage's PC enable as backpressure and presents the oldest entry to ID with a valid/ready handshake.
- Discards all queued wrong-path entries on a control-flow redirect.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr_F  in  32  instruction currently output by IF.
- PC4_F  in  32  PC+4 of that instruction.
- PC8_F  in  32  PC+8 of that instruction.
- flush  in  1  redirect in progress (same cycle IF is told to load the new PC); discard contents.
- if_en  out  1  PC enable to IF; 1 = PC advances this edge and the current IF triple is captured.
- id_ready  in  1  ID accepts the head entry this cycle (ID not stalled).
- valid_D  out  1  head entry present.
- Instr_D  out  32  head instruction.
- PC4_D  out  32  head PC+4.
- PC8_D  out  32  head PC+8.
- count  out  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All storage cleared to 0, so Instr_D/PC4_D/PC8_D=0.
  - valid_D=0, if_en=1.
  - Reset mid-operation drops everything immediately, with no clock edge needed.
- Combinational outputs:
  - full = (count==DEPTH).
  - if_en = ~full | flush. Depends only on registered count and flush, never on id_ready, so there is no loop through ID.
  - valid_D = (count!=0).
  - Head data = storage[rd_ptr], read combinationally. Latency from IF capture edge to valid_D/head = 1 cycle.
- push = if_en & ~flush: write {Instr_F,PC4_F,PC8_F} at wr_ptr, then wr_ptr+1 mod DEPTH.
- pop = valid_D & id_ready & ~flush: rd_ptr+1 mod DEPTH.
- Count update:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - both or neither: unchanged.
- Boundary conditions:
  - Full: if_en=0, IF PC holds, no push. Pop still allowed; if_en rises the cycle after the pop.
  - Empty: valid_D=0. id_ready is ignored and pointers do not move.
  - Wrap-around: pointers are AW bits and wrap naturally. Full/empty are disambiguated by count only.
  - Flush:
    - if_en forced 1 even when full, so IF loads the redirect target.
    - At the edge: wr_ptr=rd_ptr=0, count=0.
    - No push, no pop that cycle; storage contents are don't-care.
    - Next cycle valid_D=0 and the target instruction is captured.
  - Flush has priority over push/pop/id_ready. The redirect source guarantees any delay-slot instruction has already been popped before asserting flush.
  - Simultaneous push+pop at count=DEPTH-1: count stays DEPTH-1, if_en stays 1.

Decomposition:
- Shared package:
  - DEPTH/AW defaults.
  - Entry width constant (96).
  - Field offsets for Instr/PC4/PC8 within an entry.
- One natural sub-module: fifo_storage_96, a DEPTH x 96 register array with write port (we, waddr, wdata) and asynchronous read (raddr, rdata), cleared on reset.
- Pointer/count/handshake control stays in if_id_fetch_queue.

Test Plan:
- Reset, then ID stalled (id_ready=0) while IF presents instructions at PC 0x3000,0x3004,... -> valid_D=1 one cycle after first edge with Instr_D from 0x3000 and PC4_D=0x3004, PC8_D=0x3008; count reaches 4, then if_en=0 and PC4_F frozen at 0x3014.
- From full, id_ready=1 for one cycle -> head advances to 0x3004 entry, count=3, if_en=1 next cycle, 0x3010 entry captured.
- Steady flow, id_ready=1 continuously -> count stays 1, every cycle consecutive PC4_D values (0x3004,0x3008,...), no gaps or duplicates across 10+ wraps.
- Full queue plus flush=1 with NPC=0x3400 -> if_en=1 during flush, next cycle count=0, valid_D=0, following cycle Instr_D is the 0x3400 instruction, PC4_D=0x3404.
- Flush coinciding with id_ready=1 and count=2 -> no pop counted, count=0 after the edge, rd_ptr=wr_ptr=0.
- Assert reset=0 asynchronously between edges with count=3 -> valid_D=0, count=0, Instr_D/PC4_D/PC8_D=0, if_en=1 immediately; normal capture resumes after release.
